// File: rtl/atc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atc_pkg
// Description : Shared defaults and helpers for the runway allocator.
// Revision    : 1.0 - initial release
// ============================================================================
package atc_pkg;

  localparam int unsigned DEF_N_RUNWAYS  = 4;
  localparam int unsigned DEF_DIR_W      = 2;
  localparam int unsigned DEF_OCC_CYCLES = 5;
  localparam int unsigned DEF_QDEPTH     = 4;
  localparam bit          DEF_ALLOW_ALT  = 1'b1;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned pref_runway(input int unsigned dir, input int unsigned n);
    return dir % n;
  endfunction

  function automatic logic [63:0] lowest_set(input logic [63:0] vec);
    return vec & (~vec + 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/runway_timer.sv
`default_nettype none
// ============================================================================
// Module      : runway_timer
// Description : Per-runway occupancy down-counter; busy while nonzero.
// Revision    : 1.0 - initial release
// ============================================================================
module runway_timer
  import atc_pkg::*;
#(
  parameter int unsigned OCC_CYCLES = DEF_OCC_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam int unsigned CNT_W = cnt_w(OCC_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(OCC_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/runway_allocator.sv
`default_nettype none
// ============================================================================
// Module      : runway_allocator
// Description : Request FIFO plus per-cycle runway dispatch and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module runway_allocator
  import atc_pkg::*;
#(
  parameter int unsigned N_RUNWAYS  = DEF_N_RUNWAYS,
  parameter int unsigned DIR_W      = DEF_DIR_W,
  parameter int unsigned OCC_CYCLES = DEF_OCC_CYCLES,
  parameter int unsigned QDEPTH     = DEF_QDEPTH,
  parameter bit          ALLOW_ALT  = DEF_ALLOW_ALT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [DIR_W-1:0]             req_dir,
  output logic                         req_ready,
  input  logic [N_RUNWAYS-1:0]         runway_closed,
  output logic                         grant_valid,
  output logic [N_RUNWAYS-1:0]         grant_onehot,
  output logic [DIR_W-1:0]             grant_dir,
  output logic [N_RUNWAYS-1:0]         busy,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int unsigned QC_W  = $clog2(QDEPTH + 1);
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [DIR_W-1:0]     fifo_q [QDEPTH];
  logic [DIR_W-1:0]     fifo_d [QDEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [QC_W-1:0]      count_q, count_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [N_RUNWAYS-1:0] grant_onehot_q, grant_onehot_d;
  logic [DIR_W-1:0]     grant_dir_q, grant_dir_d;

  logic [N_RUNWAYS-1:0] avail;
  logic [N_RUNWAYS-1:0] pref_oh;
  logic [N_RUNWAYS-1:0] alt_oh;
  logic [N_RUNWAYS-1:0] sel_oh;
  logic [DIR_W-1:0]     head_dir;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign req_ready = (count_q < QC_W'(QDEPTH));
  assign head_dir  = fifo_q[rd_ptr_q];
  assign avail     = ~busy & ~runway_closed;
  assign pref_oh   = N_RUNWAYS'(1) << pref_runway(32'(head_dir), N_RUNWAYS);
  assign alt_oh    = N_RUNWAYS'(lowest_set(64'(avail)));

  // Dispatch looks only at registered state; the choice commits at the next edge.
  always_comb begin
    sel_oh = '0;
    if (count_q != '0) begin
      if ((pref_oh & avail) != '0) begin
        sel_oh = pref_oh;
      end else if (ALLOW_ALT) begin
        sel_oh = alt_oh;
      end
    end
  end

  assign do_pop  = (sel_oh != '0);
  assign do_push = req_valid && req_ready;

  always_comb begin
    fifo_d         = fifo_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    grant_valid_d  = do_pop;
    grant_onehot_d = sel_oh;
    grant_dir_d    = do_pop ? head_dir : '0;

    if (do_push) begin
      fifo_d[wr_ptr_q] = req_dir;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q         <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
      grant_dir_q    <= '0;
    end else begin
      fifo_q         <= fifo_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
      grant_dir_q    <= grant_dir_d;
    end
  end

  generate
    for (genvar r = 0; r < N_RUNWAYS; r++) begin : g_timer
      runway_timer #(
        .OCC_CYCLES(OCC_CYCLES)
      ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (sel_oh[r]),
        .busy (busy[r])
      );
    end
  endgenerate

  assign grant_valid  = grant_valid_q;
  assign grant_onehot = grant_onehot_q;
  assign grant_dir    = grant_dir_q;
  assign q_count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_runway_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_runway_allocator
// Description : Bench for runway_allocator; instance 0 allows alternates, 1 does not.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_runway_allocator;

  localparam int N   = 4;
  localparam int OCC = 5;
  localparam int QD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid [2];
  logic [1:0] req_dir   [2];
  logic [3:0] closed    [2];
  logic       ready     [2];
  logic       gv        [2];
  logic [3:0] oh        [2];
  logic [1:0] gdir      [2];
  logic [3:0] busy      [2];
  logic [2:0] qc        [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  runway_allocator #(.N_RUNWAYS(N), .DIR_W(2), .OCC_CYCLES(OCC), .QDEPTH(QD), .ALLOW_ALT(1'b1)) u_dut_alt (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_dir(req_dir[0]), .req_ready(ready[0]),
    .runway_closed(closed[0]), .grant_valid(gv[0]), .grant_onehot(oh[0]), .grant_dir(gdir[0]),
    .busy(busy[0]), .q_count(qc[0]));

  runway_allocator #(.N_RUNWAYS(N), .DIR_W(2), .OCC_CYCLES(OCC), .QDEPTH(QD), .ALLOW_ALT(1'b0)) u_dut_wait (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_dir(req_dir[1]), .req_ready(ready[1]),
    .runway_closed(closed[1]), .grant_valid(gv[1]), .grant_onehot(oh[1]), .grant_dir(gdir[1]),
    .busy(busy[1]), .q_count(qc[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending directions and, per runway, the first
  // edge number at which it may be granted again.
  typedef int iq_t[$];
  iq_t        mq [2];
  int         free_at [2][N];
  int         n_edge;
  bit         alt_of [2] = '{1'b1, 1'b0};
  logic       e_gv   [2];
  logic [3:0] e_oh   [2];
  logic [1:0] e_dir  [2];
  logic [3:0] e_busy [2];
  int         e_qc   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge = 0;
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        for (int r = 0; r < N; r++) free_at[i][r] = 0;
        e_gv[i] = 1'b0; e_oh[i] = '0; e_dir[i] = '0; e_busy[i] = '0; e_qc[i] = 0;
      end
    end else begin
      n_edge++;
      for (int i = 0; i < 2; i++) begin
        int pick;
        int pre;
        pick = -1;
        pre  = mq[i].size();
        if (pre > 0) begin
          int p;
          p = mq[i][0] % N;
          if (!closed[i][p] && n_edge >= free_at[i][p]) pick = p;
          else if (alt_of[i]) begin
            for (int r = N - 1; r >= 0; r--)
              if (!closed[i][r] && n_edge >= free_at[i][r]) pick = r;
          end
        end
        if (pick >= 0) begin
          e_gv[i]  = 1'b1;
          e_oh[i]  = 4'(1 << pick);
          e_dir[i] = 2'(mq[i][0]);
          void'(mq[i].pop_front());
          free_at[i][pick] = n_edge + OCC + 1;
        end else begin
          e_gv[i] = 1'b0; e_oh[i] = '0; e_dir[i] = '0;
        end
        if (req_valid[i] && pre < QD) mq[i].push_back(int'(req_dir[i]));
        for (int r = 0; r < N; r++) e_busy[i][r] = (n_edge + 1 < free_at[i][r]);
        e_qc[i] = mq[i].size();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d.grant_valid", i),  32'(gv[i]),    32'(e_gv[i]));
        check($sformatf("m%0d.grant_onehot", i), 32'(oh[i]),    32'(e_oh[i]));
        check($sformatf("m%0d.grant_dir", i),    32'(gdir[i]),  32'(e_dir[i]));
        check($sformatf("m%0d.busy", i),         32'(busy[i]),  32'(e_busy[i]));
        check($sformatf("m%0d.q_count", i),      32'(qc[i]),    32'(e_qc[i]));
        check($sformatf("m%0d.req_ready", i),    32'(ready[i]), 32'(e_qc[i] < QD));
      end
    end
  end

  // Holds req_valid until accepted; returns 1ns after the accepting edge.
  task automatic push(input int i, input logic [1:0] d);
    bit ok;
    bit r;
    int k;
    ok = 1'b0;
    k  = 0;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_dir[i]   = d;
    while (!ok && k < 40) begin
      r = ready[i];
      @(posedge clk);
      #1;
      if (r) ok = 1'b1;
      k++;
    end
    req_valid[i] = 1'b0;
    if (!ok) check($sformatf("push_timeout%0d", i), 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic single_dir2(input string tag);
    push(0, 2'd2);
    @(negedge clk);
    check({tag, ".no_grant_yet"}, 32'(gv[0]), 32'd0);
    @(negedge clk);
    check({tag, ".gv"},   32'(gv[0]),   32'd1);
    check({tag, ".oh"},   32'(oh[0]),   32'h4);
    check({tag, ".dir"},  32'(gdir[0]), 32'd2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check({tag, ".busy2_held"}, 32'(busy[0][2]), 32'd1);
      check({tag, ".gv_pulse"},   32'(gv[0]),      32'd0);
    end
    @(negedge clk);
    check({tag, ".busy2_free"}, 32'(busy[0][2]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b1; req_dir[i] = 2'd3; closed[i] = 4'(($urandom) & 32'hF);
    end
    // Reset state with arbitrary inputs applied
    idle(3);
    check("rst.busy", 32'(busy[0]), 32'd0);
    check("rst.gv",   32'(gv[0]),   32'd0);
    check("rst.qc",   32'(qc[0]),   32'd0);
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_dir[i] = '0; closed[i] = '0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.ready", 32'(ready[0]), 32'd1);

    single_dir2("s2");
    idle(2);

    // Alternate runway on consecutive edges
    push(0, 2'd0);
    push(0, 2'd0);
    @(negedge clk);
    check("s3.first_oh",  32'(oh[0]), 32'h1);
    @(negedge clk);
    check("s3.second_oh", 32'(oh[0]), 32'h2);
    idle(8);

    // Wait for the preferred runway when alternates are disabled
    push(1, 2'd0);
    push(1, 2'd0);
    @(negedge clk);
    check("s4.first_oh", 32'(oh[1]), 32'h1);
    check("s4.qc",       32'(qc[1]), 32'd1);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      check("s4.wait_gv", 32'(gv[1]), 32'd0);
      check("s4.wait_qc", 32'(qc[1]), 32'd1);
    end
    @(negedge clk);
    check("s4.second_gv", 32'(gv[1]), 32'd1);
    check("s4.second_oh", 32'(oh[1]), 32'h1);
    idle(8);

    // All closed: queue fills, then drains in order once opened
    closed[0] = 4'hF;
    push(0, 2'd0);
    push(0, 2'd1);
    push(0, 2'd2);
    push(0, 2'd3);
    fork
      push(0, 2'd0);
      begin
        idle(3);
        check("s5.full_qc",    32'(qc[0]),    32'd4);
        check("s5.full_ready", 32'(ready[0]), 32'd0);
        closed[0] = 4'h0;
        @(negedge clk);
        check("s5.g1", 32'(oh[0]), 32'h1);
        check("s5.qc_after_g1", 32'(qc[0]), 32'd3);
        @(negedge clk);
        check("s5.g2", 32'(oh[0]), 32'h2);
        @(negedge clk);
        check("s5.g3", 32'(oh[0]), 32'h4);
        @(negedge clk);
        check("s5.g4", 32'(oh[0]), 32'h8);
        @(negedge clk);
        check("s5.gap5", 32'(gv[0]), 32'd0);
        @(negedge clk);
        check("s5.gap6", 32'(gv[0]), 32'd0);
        @(negedge clk);
        check("s5.g5_gv", 32'(gv[0]), 32'd1);
        check("s5.g5_oh", 32'(oh[0]), 32'h1);
      end
    join
    idle(8);

    // Asynchronous reset mid-operation
    closed[0] = 4'b1100;
    push(0, 2'd0);
    push(0, 2'd1);
    push(0, 2'd2);
    push(0, 2'd2);
    push(0, 2'd2);
    @(negedge clk);
    check("s6.pre_busy", 32'(busy[0]), 32'h3);
    check("s6.pre_qc",   32'(qc[0]),   32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6.busy", 32'(busy[0]), 32'd0);
    check("s6.qc",   32'(qc[0]),   32'd0);
    check("s6.gv",   32'(gv[0]),   32'd0);
    check("s6.oh",   32'(oh[0]),   32'd0);
    check("s6.dir",  32'(gdir[0]), 32'd0);
    @(negedge clk);
    closed[0] = 4'h0;
    rst_n = 1'b1;
    @(negedge clk);
    check("s6.ready", 32'(ready[0]), 32'd1);
    single_dir2("s6r");
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
